// File: rtl/sctag_cpx_req_ctl_if.sv
// Bundles the sctag-side push port, the CPX request/data/grant buses and the
// debug taps (FSM state, FIFO fill, per-destination outstanding counts).
interface sctag_cpx_req_ctl_if #(
    parameter int DW     = 145,
    parameter int NDEST  = 8,
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    // Push handshake: a packet transfers on any rising edge where in_vld && in_rdy;
    // in_rdy depends only on registered state, never on in_vld.
    logic              in_vld;
    logic              in_rdy;
    logic [NDEST-1:0]  in_dest;
    logic              in_atom;
    logic [DW-1:0]     in_data;

    logic [NDEST-1:0]  sctag_cpx_req_cq;
    logic              sctag_cpx_atom_cq;
    logic [DW-1:0]     sctag_cpx_data_ca;
    logic [NDEST-1:0]  cpx_sctag_grant_cx;
    logic              dest_err;
    logic              cred_err;

    logic              dbg_state;
    logic [CW-1:0]     dbg_fifo_cnt;
    logic [2*NDEST-1:0] dbg_out_cnt;

    modport master (
        output in_vld, in_dest, in_atom, in_data, cpx_sctag_grant_cx,
        input  in_rdy, sctag_cpx_req_cq, sctag_cpx_atom_cq, sctag_cpx_data_ca,
        input  dest_err, cred_err, dbg_state, dbg_fifo_cnt, dbg_out_cnt
    );

    modport slave (
        input  in_vld, in_dest, in_atom, in_data, cpx_sctag_grant_cx,
        output in_rdy, sctag_cpx_req_cq, sctag_cpx_atom_cq, sctag_cpx_data_ca,
        output dest_err, cred_err, dbg_state, dbg_fifo_cnt, dbg_out_cnt
    );
endinterface

// File: rtl/sctag_cpx_req_ctl.sv
// L2 bank return-path sequencer: strict-order packet FIFO feeding the CPX
// request/atomic/data buses with per-destination credit tracking.
module sctag_cpx_req_ctl #(
    parameter int DW      = 145,
    parameter int QDEPTH  = 4,
    parameter int NDEST   = 8,
    parameter int CREDITS = 2
) (
    input logic               rclk,
    input logic               arst_l,
    sctag_cpx_req_ctl_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] CRED = 2'(CREDITS);

    typedef enum logic {ST_IDLE = 1'b0, ST_ATOM2 = 1'b1} state_t;

    state_t           r_state;
    logic [NDEST-1:0] r_atom_dest;
    logic [NDEST-1:0] r_req;
    logic             r_atom;
    logic [DW-1:0]    r_data_hold;
    logic [DW-1:0]    r_data_ca;
    logic             r_dest_err;
    logic             r_cred_err;
    logic [1:0]       r_out_cnt [NDEST];

    logic [DW-1:0]    r_mem_data [QDEPTH];
    logic [NDEST-1:0] r_mem_dest [QDEPTH];
    logic             r_mem_atom [QDEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic             w_issue_atom;
    logic [NDEST-1:0] w_issue_dest;
    logic             w_dest_err;
    logic             w_cred_err;
    logic [DW-1:0]    w_head_data;
    logic [NDEST-1:0] w_head_dest;
    logic             w_head_atom;
    logic             w_onehot;
    logic [1:0]       w_head_cnt;
    logic [NDEST-1:0] w_inc;

    assign bus.in_rdy = (r_count < CW'(QDEPTH));
    assign w_push     = bus.in_vld & bus.in_rdy;

    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_dest = r_mem_dest[r_rptr];
    assign w_head_atom = r_mem_atom[r_rptr];
    assign w_onehot    = (w_head_dest != '0) && ((w_head_dest & (w_head_dest - 1'b1)) == '0);

    always_comb begin
        w_head_cnt = '0;
        for (int d = 0; d < NDEST; d++)
            if (w_head_dest[d]) w_head_cnt = r_out_cnt[d];
    end

    // Credit decisions look only at the registered counts; a grant arriving
    // this cycle cannot unblock an issue until the next one.
    always_comb begin
        w_issue      = 1'b0;
        w_issue_atom = 1'b0;
        w_issue_dest = '0;
        w_pop        = 1'b0;
        w_dest_err   = 1'b0;
        if (r_state == ST_ATOM2) begin
            if (r_count != '0) begin
                w_issue      = 1'b1;
                w_issue_dest = r_atom_dest;
                w_pop        = 1'b1;
            end
        end else if (r_count != '0) begin
            if (!w_onehot) begin
                w_pop      = 1'b1;
                w_dest_err = 1'b1;
            end else if (!w_head_atom) begin
                if (w_head_cnt < CRED) begin
                    w_issue      = 1'b1;
                    w_issue_dest = w_head_dest;
                    w_pop        = 1'b1;
                end
            end else if ((r_count >= CW'(2)) && (w_head_cnt == 2'd0)) begin
                w_issue      = 1'b1;
                w_issue_atom = 1'b1;
                w_issue_dest = w_head_dest;
                w_pop        = 1'b1;
            end
        end
    end

    assign w_inc = w_issue ? w_issue_dest : '0;

    always_comb begin
        w_cred_err = 1'b0;
        for (int d = 0; d < NDEST; d++)
            if (bus.cpx_sctag_grant_cx[d] && !w_inc[d] && (r_out_cnt[d] == 2'd0))
                w_cred_err = 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (w_push) begin
            r_mem_data[r_wptr] <= bus.in_data;
            r_mem_dest[r_wptr] <= bus.in_dest;
            r_mem_atom[r_wptr] <= bus.in_atom;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int d = 0; d < NDEST; d++) r_out_cnt[d] <= 2'd0;
        end else begin
            for (int d = 0; d < NDEST; d++) begin
                case ({w_inc[d], bus.cpx_sctag_grant_cx[d]})
                    2'b10:   if (r_out_cnt[d] != 2'd3) r_out_cnt[d] <= r_out_cnt[d] + 2'd1;
                    2'b01:   if (r_out_cnt[d] != 2'd0) r_out_cnt[d] <= r_out_cnt[d] - 2'd1;
                    default: r_out_cnt[d] <= r_out_cnt[d];
                endcase
            end
        end
    end

    // Data is staged once so it trails its request by exactly one cycle.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state     <= ST_IDLE;
            r_atom_dest <= '0;
            r_req       <= '0;
            r_atom      <= 1'b0;
            r_data_hold <= '0;
            r_data_ca   <= '0;
            r_dest_err  <= 1'b0;
            r_cred_err  <= 1'b0;
        end else begin
            r_req       <= w_inc;
            r_atom      <= w_issue_atom;
            r_data_hold <= w_issue ? w_head_data : '0;
            r_data_ca   <= r_data_hold;
            r_dest_err  <= w_dest_err;
            r_cred_err  <= w_cred_err;
            case (r_state)
                ST_IDLE: if (w_issue_atom) begin
                    r_state     <= ST_ATOM2;
                    r_atom_dest <= w_head_dest;
                end
                ST_ATOM2: if (w_issue) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sctag_cpx_req_cq  = r_req;
    assign bus.sctag_cpx_atom_cq = r_atom;
    assign bus.sctag_cpx_data_ca = r_data_ca;
    assign bus.dest_err          = r_dest_err;
    assign bus.cred_err          = r_cred_err;
    assign bus.dbg_state         = r_state;
    assign bus.dbg_fifo_cnt      = r_count;

    always_comb begin
        bus.dbg_out_cnt = '0;
        for (int d = 0; d < NDEST; d++) bus.dbg_out_cnt[2*d +: 2] = r_out_cnt[d];
    end
endmodule

// File: tb/tb_sctag_cpx_req_ctl.sv
// Directed bench for sctag_cpx_req_ctl: a scoreboard pairs each pushed packet
// with the request and data the CPX side should observe.
module tb_sctag_cpx_req_ctl;
  localparam int DW = 145;
  localparam int NDEST = 8;
  localparam int QDEPTH = 4;

  logic rclk;
  logic arst_l;
  int vec_cnt = 0;
  int err_cnt = 0;
  int req_seen = 0;
  int seen0;

  logic [NDEST:0]  exp_q[$];
  logic [DW-1:0]   exp_data_q[$];

  sctag_cpx_req_ctl_if #(.DW(DW), .NDEST(NDEST), .QDEPTH(QDEPTH)) bus ();

  sctag_cpx_req_ctl #(.DW(DW), .QDEPTH(QDEPTH), .NDEST(NDEST), .CREDITS(2)) dut (
    .rclk  (rclk),
    .arst_l(arst_l),
    .bus   (bus)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ocnt(input int d);
    return bus.dbg_out_cnt[2*d +: 2];
  endfunction

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [NDEST-1:0] dest, input logic atom,
                      input logic [DW-1:0] data, input bit expect_req);
    bus.in_vld  = 1'b1;
    bus.in_dest = dest;
    bus.in_atom = atom;
    bus.in_data = data;
    if (expect_req) begin
      exp_q.push_back({dest, atom});
      exp_data_q.push_back(data);
    end
    @(posedge rclk);
    #1;
    bus.in_vld  = 1'b0;
    bus.in_atom = 1'b0;
  endtask

  task automatic grant(input logic [NDEST-1:0] mask);
    bus.cpx_sctag_grant_cx = mask;
    @(posedge rclk);
    #1;
    bus.cpx_sctag_grant_cx = '0;
  endtask

  // scoreboard monitor
  always @(negedge rclk) begin
    if (arst_l) begin
      if (bus.sctag_cpx_req_cq != '0) begin
        req_seen++;
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_req: got unexpected req %0h atom %0b", bus.sctag_cpx_req_cq, bus.sctag_cpx_atom_cq);
        end else begin
          chk("sb_req", {bus.sctag_cpx_req_cq, bus.sctag_cpx_atom_cq}, exp_q.pop_front());
        end
      end
      if (bus.sctag_cpx_data_ca != '0) begin
        if (exp_data_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL sb_data: got unexpected data %0h", bus.sctag_cpx_data_ca);
        end else begin
          chk("sb_data", bus.sctag_cpx_data_ca, exp_data_q.pop_front());
        end
      end
    end
  end

  initial begin
    arst_l = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_dest = '0;
    bus.in_atom = 1'b0;
    bus.in_data = '0;
    bus.cpx_sctag_grant_cx = '0;
    repeat (3) @(posedge rclk);
    #2 arst_l = 1'b1;
    cyc(1);

    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_req", bus.sctag_cpx_req_cq, 0);
    chk("rst_atom", bus.sctag_cpx_atom_cq, 0);
    chk("rst_data", bus.sctag_cpx_data_ca, 0);
    chk("rst_errs", {bus.dest_err, bus.cred_err}, 0);
    chk("rst_fifo", bus.dbg_fifo_cnt, 0);
    chk("rst_state", bus.dbg_state, 0);

    // single packet latency
    push(8'h04, 1'b0, 145'h1234, 1'b1);
    @(negedge rclk); chk("s1_req_after_e0", bus.sctag_cpx_req_cq, 0);
    @(negedge rclk); chk("s1_req_after_e1", bus.sctag_cpx_req_cq, 8'h04);
    chk("s1_data_after_e1", bus.sctag_cpx_data_ca, 0);
    @(negedge rclk); chk("s1_data_after_e2", bus.sctag_cpx_data_ca, 145'h1234);
    chk("s1_out_cnt2", ocnt(2), 1);
    grant(8'h04);
    cyc(1);
    chk("s1_out_cnt2_freed", ocnt(2), 0);

    // credit limit of two, third held until a grant
    seen0 = req_seen;
    push(8'h01, 1'b0, 145'h11, 1'b1);
    push(8'h01, 1'b0, 145'h22, 1'b1);
    push(8'h01, 1'b0, 145'h33, 1'b1);
    cyc(3);
    chk("s2_two_issued", 32'(req_seen - seen0), 2);
    chk("s2_out_cnt0", ocnt(0), 2);
    chk("s2_fifo_held", bus.dbg_fifo_cnt, 1);
    grant(8'h01);
    @(negedge rclk); chk("s2_req_after_eg", bus.sctag_cpx_req_cq, 0);
    @(negedge rclk); chk("s2_req_after_eg1", bus.sctag_cpx_req_cq, 8'h01);
    grant(8'h01);
    grant(8'h01);
    cyc(2);
    chk("s2_out_cnt0_freed", ocnt(0), 0);

    // atomic pair stalls until the destination is fully drained
    push(8'h10, 1'b0, 145'hA0, 1'b1);
    cyc(3);
    push(8'h10, 1'b1, 145'hA1, 1'b1);
    push(8'h10, 1'b0, 145'hA2, 1'b1);
    cyc(4);
    chk("s3_stall_req", bus.sctag_cpx_req_cq, 0);
    chk("s3_stall_fifo", bus.dbg_fifo_cnt, 2);
    chk("s3_stall_cnt4", ocnt(4), 1);
    grant(8'h10);
    @(negedge rclk); chk("s3_req_after_eg", bus.sctag_cpx_req_cq, 0);
    @(negedge rclk); chk("s3_beat1", {bus.sctag_cpx_req_cq, bus.sctag_cpx_atom_cq}, {8'h10, 1'b1});
    chk("s3_state_atom2", bus.dbg_state, 1);
    @(negedge rclk); chk("s3_beat2", {bus.sctag_cpx_req_cq, bus.sctag_cpx_atom_cq}, {8'h10, 1'b0});
    chk("s3_data1", bus.sctag_cpx_data_ca, 145'hA1);
    chk("s3_state_idle", bus.dbg_state, 0);
    @(negedge rclk); chk("s3_data2", bus.sctag_cpx_data_ca, 145'hA2);
    chk("s3_out_cnt4", ocnt(4), 2);
    grant(8'h10);
    grant(8'h10);
    cyc(2);
    chk("s3_out_cnt4_freed", ocnt(4), 0);

    // fill the FIFO behind an exhausted destination
    push(8'h02, 1'b0, 145'hB0, 1'b1);
    push(8'h02, 1'b0, 145'hB1, 1'b1);
    for (int i = 2; i < 6; i++) push(8'h02, 1'b0, 145'(32'hB0 + i), 1'b1);
    cyc(1);
    chk("s4_full_rdy", bus.in_rdy, 0);
    chk("s4_full_fifo", bus.dbg_fifo_cnt, 4);
    chk("s4_out_cnt1", ocnt(1), 2);
    push(8'h02, 1'b0, 145'hBAD, 1'b0);
    chk("s4_fifth_ignored", bus.dbg_fifo_cnt, 4);
    grant(8'h02);
    @(negedge rclk); chk("s4_rdy_after_eg", bus.in_rdy, 0);
    @(negedge rclk); chk("s4_rdy_after_eg1", bus.in_rdy, 1);
    chk("s4_fifo_after_pop", bus.dbg_fifo_cnt, 3);
    repeat (5) begin
      grant(8'h02);
      cyc(1);
    end
    cyc(3);
    chk("s4_out_cnt1_freed", ocnt(1), 0);
    chk("s4_fifo_drained", bus.dbg_fifo_cnt, 0);

    // error pulses
    grant(8'h80);
    chk("s5_cred_err", bus.cred_err, 1);
    chk("s5_out_cnt7", ocnt(7), 0);
    cyc(1);
    chk("s5_cred_err_pulse", bus.cred_err, 0);
    push(8'h03, 1'b0, 145'hC3, 1'b0);
    chk("s5_dest_err_early", bus.dest_err, 0);
    cyc(1);
    chk("s5_dest_err", bus.dest_err, 1);
    chk("s5_dest_err_noreq", bus.sctag_cpx_req_cq, 0);
    chk("s5_dest_err_popped", bus.dbg_fifo_cnt, 0);
    cyc(1);
    chk("s5_dest_err_pulse", bus.dest_err, 0);

    // reset in the middle of an atomic pair
    push(8'h20, 1'b1, 145'hD1, 1'b1);
    push(8'h20, 1'b0, 145'hD2, 1'b1);
    chk("s6_pre_state", bus.dbg_state, 0);
    cyc(1);
    chk("s6_in_atom2", bus.dbg_state, 1);
    chk("s6_beat1", {bus.sctag_cpx_req_cq, bus.sctag_cpx_atom_cq}, {8'h20, 1'b1});
    #1 arst_l = 1'b0;
    #1;
    chk("s6_rst_req", bus.sctag_cpx_req_cq, 0);
    chk("s6_rst_atom", bus.sctag_cpx_atom_cq, 0);
    chk("s6_rst_data", bus.sctag_cpx_data_ca, 0);
    chk("s6_rst_errs", {bus.dest_err, bus.cred_err}, 0);
    chk("s6_rst_state", bus.dbg_state, 0);
    chk("s6_rst_fifo", bus.dbg_fifo_cnt, 0);
    chk("s6_rst_cnt5", ocnt(5), 0);
    exp_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge rclk);
    #3 arst_l = 1'b1;
    #1;
    chk("s6_rel_rdy", bus.in_rdy, 1);
    push(8'h01, 1'b0, 145'hE1, 1'b1);
    @(negedge rclk); chk("s6_req_after_e0", bus.sctag_cpx_req_cq, 0);
    @(negedge rclk); chk("s6_req_after_e1", bus.sctag_cpx_req_cq, 8'h01);
    @(negedge rclk); chk("s6_data_after_e2", bus.sctag_cpx_data_ca, 145'hE1);

    // final report
    cyc(4);
    chk("sb_req_drained", 32'(exp_q.size()), 0);
    chk("sb_data_drained", 32'(exp_data_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
